// File: rtl/vga_pkg.sv
// Shared VGA timing constants, frame buffer depth and the 16-entry colour table
// used by pbuf_vga_scanout.
package vga_pkg;

   localparam int unsigned H_ACT  = 640;
   localparam int unsigned H_FP   = 16;
   localparam int unsigned H_SYNC = 96;
   localparam int unsigned H_BP   = 48;
   localparam int unsigned H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_ACT  = 480;
   localparam int unsigned V_FP   = 10;
   localparam int unsigned V_SYNC = 2;
   localparam int unsigned V_BP   = 33;
   localparam int unsigned V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;

   localparam int unsigned FB_DEPTH = 160 * 120;

   // {r, g, b}, 4 bits each
   localparam logic [11:0] PALETTE [16] = '{
      12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
      12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
   };

endpackage

// File: rtl/vga_timing.sv
// 25 MHz pixel strobe, horizontal/vertical scan counters and raw (undelayed)
// sync, blank and frame_tick for the scan-out path.
module vga_timing
   import vga_pkg::*;
#(
   parameter int unsigned V_ACTIVE = V_ACT,
   parameter int unsigned V_FPORCH = V_FP,
   parameter int unsigned V_SYNCW  = V_SYNC,
   parameter int unsigned V_BPORCH = V_BP
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   output logic       o_pix_en,
   output logic [9:0] o_hcnt,
   output logic [9:0] o_vcnt,
   output logic       o_hs,
   output logic       o_vs,
   output logic       o_blank,
   output logic       o_frame_tick
);

   localparam int unsigned V_TOTAL = V_ACTIVE + V_FPORCH + V_SYNCW + V_BPORCH;

   logic       r_pix_en;
   logic [9:0] r_hcnt;
   logic [9:0] r_vcnt;
   logic       w_h_last;
   logic       w_v_last;

   assign w_h_last = (r_hcnt == 10'(H_TOT - 1));
   assign w_v_last = (r_vcnt == 10'(V_TOTAL - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pix_en <= 1'b0;
         r_hcnt   <= '0;
         r_vcnt   <= '0;
      end else begin
         r_pix_en <= ~r_pix_en;
         if (r_pix_en) begin
            if (w_h_last) begin
               r_hcnt <= '0;
               r_vcnt <= w_v_last ? '0 : r_vcnt + 10'd1;
            end else begin
               r_hcnt <= r_hcnt + 10'd1;
            end
         end
      end
   end

   assign o_pix_en = r_pix_en;
   assign o_hcnt   = r_hcnt;
   assign o_vcnt   = r_vcnt;
   assign o_hs     = !((r_hcnt >= 10'(H_ACT + H_FP)) && (r_hcnt < 10'(H_ACT + H_FP + H_SYNC)));
   assign o_vs     = !((r_vcnt >= 10'(V_ACTIVE + V_FPORCH)) &&
                       (r_vcnt < 10'(V_ACTIVE + V_FPORCH + V_SYNCW)));
   assign o_blank  = (r_hcnt >= 10'(H_ACT)) || (r_vcnt >= 10'(V_ACTIVE));
   assign o_frame_tick = r_pix_en && (r_hcnt == '0) && (r_vcnt == 10'(V_ACTIVE));

endmodule

// File: rtl/pbuf_vga_scanout.sv
// Pixel-buffer frame store (160x120x4) with 640x480@60 VGA scan-out, 4x replication.
// Define VGA_PALETTE_EN to map pixels through the 16-colour table; default is greyscale.
module pbuf_vga_scanout
   import vga_pkg::*;
#(
   parameter int unsigned FB_W     = 160,
   parameter int unsigned FB_H     = 120,
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned PIX_W    = 4,
   parameter int unsigned SCALE_SH = 2,
   parameter int unsigned V_ACTIVE = V_ACT,
   parameter int unsigned V_FPORCH = V_FP,
   parameter int unsigned V_SYNCW  = V_SYNC,
   parameter int unsigned V_BPORCH = V_BP
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic [ADDR_W-1:0] pb_adr_export,
   input  logic [PIX_W-1:0]  pb_data_export,
   input  logic              pbuff_wren_export,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              frame_tick
);

   localparam int unsigned FB_SIZE = FB_W * FB_H;

   logic              w_pix_en;
   logic [9:0]        w_hcnt;
   logic [9:0]        w_vcnt;
   logic              w_hs;
   logic              w_vs;
   logic              w_blank;
   logic              w_frame_tick;
   logic [9:0]        w_x;
   logic [9:0]        w_y;
   logic [ADDR_W-1:0] w_rd_adr;
   logic              w_we;
   logic [11:0]       w_rgb;

   logic [PIX_W-1:0]  r_mem [FB_SIZE];
   logic [PIX_W-1:0]  r_rd_data;
   logic              r_wren_q;
   logic              r_hs1;
   logic              r_vs1;
   logic              r_blank1;
   logic              r_hs2;
   logic              r_vs2;
   logic [11:0]       r_rgb;

   vga_timing #(
      .V_ACTIVE (V_ACTIVE),
      .V_FPORCH (V_FPORCH),
      .V_SYNCW  (V_SYNCW),
      .V_BPORCH (V_BPORCH)
   ) u_timing (
      .i_clk        (clk_clk),
      .i_rst_n      (reset_reset_n),
      .o_pix_en     (w_pix_en),
      .o_hcnt       (w_hcnt),
      .o_vcnt       (w_vcnt),
      .o_hs         (w_hs),
      .o_vs         (w_vs),
      .o_blank      (w_blank),
      .o_frame_tick (w_frame_tick)
   );

   // y*160 + x as shifts; parked at 0 during blanking so the index stays in range
   assign w_x      = w_hcnt >> SCALE_SH;
   assign w_y      = w_vcnt >> SCALE_SH;
   assign w_rd_adr = w_blank ? '0 :
                     (ADDR_W'(w_y) << 7) + (ADDR_W'(w_y) << 5) + ADDR_W'(w_x);

   assign w_we = reset_reset_n && pbuff_wren_export && !r_wren_q &&
                 (pb_adr_export < ADDR_W'(FB_SIZE));

   // Single process for write and read gives read-before-write on a shared address
   always_ff @(posedge clk_clk) begin
      if (w_we) r_mem[pb_adr_export] <= pb_data_export;
      if (w_pix_en) r_rd_data <= r_mem[w_rd_adr];
   end

   always_comb begin
      w_rgb = '0;
`ifdef VGA_PALETTE_EN
      w_rgb = PALETTE[r_rd_data];
`else
      w_rgb = {3{r_rd_data}};
`endif
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_wren_q <= 1'b0;
         r_hs1    <= 1'b1;
         r_vs1    <= 1'b1;
         r_blank1 <= 1'b1;
         r_hs2    <= 1'b1;
         r_vs2    <= 1'b1;
         r_rgb    <= '0;
      end else begin
         r_wren_q <= pbuff_wren_export;
         if (w_pix_en) begin
            r_hs1    <= w_hs;
            r_vs1    <= w_vs;
            r_blank1 <= w_blank;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_rgb    <= r_blank1 ? '0 : w_rgb;
         end
      end
   end

   assign vga_r      = r_rgb[11:8];
   assign vga_g      = r_rgb[7:4];
   assign vga_b      = r_rgb[3:0];
   assign vga_hs     = r_hs2;
   assign vga_vs     = r_vs2;
   assign frame_tick = w_frame_tick;

endmodule
